// File: rtl/pipe_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, pcsource codes,
// reset constants and the redirect-target selector.
package pipe_if_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_FETCH = 2'b01,
        IF_HOLD  = 2'b10
    } if_state_e;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BPC = 2'b01;
    localparam logic [1:0] PCSRC_DA  = 2'b10;
    localparam logic [1:0] PCSRC_JPC = 2'b11;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    // Only meaningful for the three redirecting codes; PC4 never reaches the PC.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  sel,
        input logic [31:0] bpc,
        input logic [31:0] da,
        input logic [31:0] jpc
    );
        logic [31:0] t;
        case (sel)
            PCSRC_BPC: t = bpc;
            PCSRC_DA:  t = da;
            PCSRC_JPC: t = jpc;
            default:   t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pipe_if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface pipe_if_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pipe_if_fetch_skid.sv
// One-entry instruction + pc4 buffer catching an ack that ID cannot accept.
module pipe_if_fetch_skid (
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc4;

    // Skid storage: load and drain never coincide because req is low while holding.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_inst  <= 32'h0000_0000;
            r_pc4   <= 32'h0000_0000;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc4   <= i_pc4;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage and IF/ID register with one branch delay slot.
// Optional perf_fetch/perf_stall counters exist when IF_FETCH_PERF_EN is defined.
module pipe_if_fetch
    import pipe_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic               clock,
    input  logic               resetn,
    pipe_if_fetch_if.master    imem,
    input  logic               nostall,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        da,
    input  logic [31:0]        jpc,
    output logic [31:0]        pc,
    output logic [31:0]        d_inst,
    output logic [31:0]        d_pc4,
    output logic               d_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall
`endif
);

    if_state_e   r_state;
    if_state_e   w_state_nx;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nx;
    logic [31:0] r_redir_pc;
    logic [31:0] w_redir_pc_nx;
    logic        r_redir_pend;
    logic        w_redir_pend_nx;
    logic [31:0] r_d_inst;
    logic [31:0] w_d_inst_nx;
    logic [31:0] r_d_pc4;
    logic [31:0] w_d_pc4_nx;
    logic        r_d_valid;
    logic        w_d_valid_nx;

    logic        w_fetching;
    logic        w_ack;
    logic        w_redir;
    logic        w_ifid_free;
    logic        w_skid_load;
    logic        w_skid_drain;
    logic        w_skid_valid;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_skid_inst;
    logic [31:0] w_skid_pc4;

    assign w_fetching   = (r_state == IF_FETCH);
    assign w_ack        = w_fetching & imem.ack;
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_redir      = r_d_valid & nostall & (pcsource != PCSRC_PC4);
    assign w_target     = redirect_target(pcsource, bpc, da, jpc);
    assign w_ifid_free  = ~r_d_valid | nostall;
    assign w_skid_load  = w_ack & ~w_ifid_free;
    assign w_skid_drain = (r_state == IF_HOLD) & nostall;

    pipe_if_fetch_skid u_skid (
        .clock   (clock),
        .resetn  (resetn),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_inst  (imem.rdata),
        .i_pc4   (w_pc_plus4),
        .o_valid (w_skid_valid),
        .o_inst  (w_skid_inst),
        .o_pc4   (w_skid_pc4)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state: park in HOLD while the skid carries an unaccepted instruction.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IF_IDLE:  w_state_nx = IF_FETCH;
            IF_FETCH: begin
                if (w_skid_load) begin
                    w_state_nx = IF_HOLD;
                end else begin
                    w_state_nx = IF_FETCH;
                end
            end
            IF_HOLD: begin
                if (nostall) begin
                    w_state_nx = IF_FETCH;
                end else begin
                    w_state_nx = IF_HOLD;
                end
            end
            default:  w_state_nx = IF_IDLE;
        endcase
    end

    // PC and deferred-redirect next state.
    always_comb begin
        w_pc_nx         = r_pc;
        w_redir_pc_nx   = r_redir_pc;
        w_redir_pend_nx = r_redir_pend;
        if (w_ack) begin
            // The arriving word is the delay slot when a redirect is taken or pending.
            if (w_redir) begin
                w_pc_nx = w_target;
            end else if (r_redir_pend) begin
                w_pc_nx = r_redir_pc;
            end else begin
                w_pc_nx = w_pc_plus4;
            end
            w_redir_pend_nx = 1'b0;
        end else if (w_redir) begin
            if (w_fetching) begin
                // Slot still in flight: its ack must advance to the target instead.
                w_redir_pc_nx   = w_target;
                w_redir_pend_nx = 1'b1;
            end else begin
                w_pc_nx = w_target;
            end
        end else begin
            w_pc_nx = r_pc;
        end
    end

    // IF/ID next state: fetch ack, skid drain, bubble on consume, or hold on stall.
    always_comb begin
        w_d_inst_nx  = r_d_inst;
        w_d_pc4_nx   = r_d_pc4;
        w_d_valid_nx = r_d_valid;
        if (w_ack && w_ifid_free) begin
            w_d_inst_nx  = imem.rdata;
            w_d_pc4_nx   = w_pc_plus4;
            w_d_valid_nx = 1'b1;
        end else if (w_skid_drain && w_skid_valid) begin
            w_d_inst_nx  = w_skid_inst;
            w_d_pc4_nx   = w_skid_pc4;
            w_d_valid_nx = 1'b1;
        end else if (nostall) begin
            w_d_inst_nx  = NOP_INST;
            w_d_valid_nx = 1'b0;
        end else begin
            w_d_valid_nx = r_d_valid;
        end
    end

    // PC, redirect and IF/ID registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc         <= RESET_PC;
            r_redir_pc   <= 32'h0000_0000;
            r_redir_pend <= 1'b0;
            r_d_inst     <= NOP_INST;
            r_d_pc4      <= 32'h0000_0000;
            r_d_valid    <= 1'b0;
        end else begin
            r_pc         <= w_pc_nx;
            r_redir_pc   <= w_redir_pc_nx;
            r_redir_pend <= w_redir_pend_nx;
            r_d_inst     <= w_d_inst_nx;
            r_d_pc4      <= w_d_pc4_nx;
            r_d_valid    <= w_d_valid_nx;
        end
    end

    assign imem.req  = w_fetching;
    assign imem.addr = r_pc;
    assign pc        = r_pc;
    assign d_inst    = r_d_inst;
    assign d_pc4     = r_d_pc4;
    assign d_valid   = r_d_valid;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Completed-fetch and ID-stall counters, free-running modulo 2^32.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_perf_fetch <= 32'h0000_0000;
            r_perf_stall <= 32'h0000_0000;
        end else begin
            r_perf_fetch <= r_perf_fetch + {31'd0, w_ack};
            r_perf_stall <= r_perf_stall + {31'd0, r_d_valid & ~nostall};
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Self-checking bench for pipe_if_fetch: program-order fetch model plus directed scenarios.
module tb_pipe_if_fetch;
    import pipe_if_fetch_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic [31:0] pc, d_inst, d_pc4;
    logic        d_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    pipe_if_fetch_if imem ();

    pipe_if_fetch #(.RESET_PC(T_RESET_PC), .NOP_INST(T_NOP)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .imem     (imem),
        .nostall  (nostall),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .pc       (pc),
        .d_inst   (d_inst),
        .d_pc4    (d_pc4),
        .d_valid  (d_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int lat = 1;
    int ack_limit = 1000000;
    int acks_given = 0;
    int wcnt = 0;
    int stall_from = 0;
    int stall_to = 0;
    bit chk_en = 1'b0;
    int bi;

    logic [31:0] br_pc[4];
    logic [31:0] br_tgt[4];
    logic [1:0]  br_src[4];
    int          n_br = 0;

    logic [31:0] stream[$];
    int          fidx = 0;
    int          cidx = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_inst, hold_pc4;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BE01;
    endfunction

    function automatic int find_br(input logic [31:0] a);
        for (int i = 0; i < n_br; i++) begin
            if (br_pc[i] == a) return i;
        end
        return -1;
    endfunction

    // Program order: a[k+2] is the target of a[k] if a[k] branches, else a[k+1]+4.
    function automatic void build_stream();
        int b;
        stream.delete();
        stream.push_back(T_RESET_PC);
        stream.push_back(T_RESET_PC + 32'd4);
        for (int k = 0; k < 300; k++) begin
            b = find_br(stream[k]);
            if (b >= 0) stream.push_back(br_tgt[b]);
            else        stream.push_back(stream[k+1] + 32'd4);
        end
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Instruction memory: ack after lat cycles of req, at most ack_limit acks per reset.
    initial begin
        imem.ack   = 1'b0;
        imem.rdata = 32'h0;
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                imem.ack = 1'b0; wcnt = 0; acks_given = 0;
            end else begin
                #1;
                if (imem.req && acks_given < ack_limit) begin
                    if (wcnt >= lat - 1) begin
                        imem.ack = 1'b1; imem.rdata = inst_of(imem.addr);
                        wcnt = 0; acks_given++;
                    end else begin
                        imem.ack = 1'b0; wcnt++;
                    end
                end else begin
                    imem.ack = 1'b0; wcnt = 0;
                end
            end
        end
    end

    // ID side: stall windows and redirect decisions; pcsource is random when ignored.
    initial begin
        nostall = 1'b1; pcsource = 2'b00; bpc = 32'h0; da = 32'h0; jpc = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            nostall  = !(cyc >= stall_from && cyc < stall_to);
            bpc      = $urandom;
            da       = $urandom;
            jpc      = $urandom;
            pcsource = 2'($urandom_range(0, 3));
            if (d_valid && nostall) begin
                bi = find_br(d_pc4 - 32'd4);
                if (bi >= 0) begin
                    pcsource = br_src[bi];
                    case (br_src[bi])
                        2'b01:   bpc = br_tgt[bi];
                        2'b10:   da  = br_tgt[bi];
                        default: jpc = br_tgt[bi];
                    endcase
                end else begin
                    pcsource = 2'b00;
                end
            end
        end
    end

    // Compare process: fetch order, consume order, stall hold and bubble contents.
    initial forever begin
        @(negedge clock);
        if (!resetn) begin
            fidx = 0; cidx = 0; hold_prev = 1'b0;
        end else if (chk_en) begin
            if (hold_prev) begin
                check32("stall_hold_inst", d_inst, hold_inst);
                check32("stall_hold_pc4", d_pc4, hold_pc4);
                check32("stall_hold_valid", {31'd0, d_valid}, 32'd1);
            end
            hold_prev = d_valid & ~nostall;
            hold_inst = d_inst;
            hold_pc4  = d_pc4;
            if (imem.req) check32("imem_addr_is_pc", imem.addr, pc);
            if (imem.req && imem.ack) begin
                if (fidx < stream.size()) check32("fetch_addr", imem.addr, stream[fidx]);
                fidx++;
            end
            if (d_valid && nostall) begin
                check32("consume_after_fetch", {31'd0, cidx < fidx}, 32'd1);
                if (cidx < stream.size()) begin
                    check32("d_pc4", d_pc4, stream[cidx] + 32'd4);
                    check32("d_inst", d_inst, inst_of(stream[cidx]));
                end
                cidx++;
            end
            if (!d_valid) check32("bubble_nop", d_inst, T_NOP);
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b0;
        repeat (2) @(negedge clock);
        check32("rst_pc", pc, T_RESET_PC);
        check32("rst_req", {31'd0, imem.req}, 32'd0);
        check32("rst_valid", {31'd0, d_valid}, 32'd0);
        check32("rst_inst", d_inst, T_NOP);
        check32("rst_pc4", d_pc4, 32'd0);
        build_stream();
        resetn = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_ifid(input string nm, input logic [31:0] v, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (d_valid && d_pc4 == v) return;
        end
        n_tests++; n_fail++;
        $display("FAIL %s: timeout waiting d_pc4 %h, got %h", nm, v, d_pc4);
    endtask

    task automatic wait_ack(input string nm, input logic [31:0] v, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (imem.req && imem.ack && (v == 32'hFFFF_FFFF || imem.addr == v)) return;
        end
        n_tests++; n_fail++;
        $display("FAIL %s: timeout waiting ack at %h, addr %h", nm, v, imem.addr);
    endtask

    task automatic run(input int n, input bit stalls);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (stalls && cyc >= stall_to && $urandom_range(0, 3) == 0) begin
                stall_from = cyc + 1;
                stall_to   = cyc + 1 + int'($urandom_range(1, 2));
            end
        end
    endtask

    initial begin
        // Sequential stream at 1-cycle imem.
        lat = 1; n_br = 0; ack_limit = 1000000;
        do_reset();
        wait_ifid("s1_first", 32'h4, 20);
        check32("s1_pc4_0", d_pc4, 32'h4);
        check32("s1_pc", pc, 32'h4);
        @(negedge clock); check32("s1_pc4_1", d_pc4, 32'h8);
        @(negedge clock); check32("s1_pc4_2", d_pc4, 32'hC);
        run(20, 1'b0);

        // Taken beq at 0x10 to 0x40: slot 0x14 then target.
        n_br = 1; br_pc[0] = 32'h10; br_src[0] = PCSRC_BPC; br_tgt[0] = 32'h40;
        do_reset();
        wait_ifid("s2_branch", 32'h14, 40);
        @(negedge clock); check32("s2_slot", d_pc4, 32'h18);
        @(negedge clock); check32("s2_target", d_pc4, 32'h44);
        check32("s2_target_inst", d_inst, 32'hDEAD_BE41);
        run(40, 1'b1);

        // 3-cycle imem: jr while slot in flight, then a jump later.
        lat = 3; n_br = 2;
        br_pc[0] = 32'h8;   br_src[0] = PCSRC_DA;  br_tgt[0] = 32'h200;
        br_pc[1] = 32'h208; br_src[1] = PCSRC_JPC; br_tgt[1] = 32'h1000;
        do_reset();
        wait_ack("s3_slot", 32'hC, 60);
        wait_ack("s3_next", 32'hFFFF_FFFF, 10);
        check32("s3_after_slot", imem.addr, 32'h200);
        run(80, 1'b1);

        // Two-cycle stall during ack; jump at 0x8 taken from HOLD with slot in skid.
        lat = 1; n_br = 1;
        br_pc[0] = 32'h8; br_src[0] = PCSRC_JPC; br_tgt[0] = 32'h300;
        do_reset();
        wait_ifid("s4_start", 32'h8, 20);
        stall_from = cyc + 1; stall_to = cyc + 3;
        @(negedge clock);
        check32("s4_n1_pc4", d_pc4, 32'hC);
        check32("s4_n1_req", {31'd0, imem.req}, 32'd1);
        @(negedge clock);
        check32("s4_hold_req", {31'd0, imem.req}, 32'd0);
        check32("s4_hold_inst", d_inst, 32'hDEAD_BE09);
        check32("s4_hold_pc4", d_pc4, 32'hC);
        @(negedge clock);
        check32("s4_hold2_req", {31'd0, imem.req}, 32'd0);
        @(negedge clock);
        check32("s4_drain_pc4", d_pc4, 32'h10);
        check32("s4_drain_inst", d_inst, 32'hDEAD_BE0D);
        check32("s4_redir_addr", imem.addr, 32'h300);
        @(negedge clock);
        check32("s4_target_pc4", d_pc4, 32'h304);
        run(30, 1'b1);

        // Exactly 10 fetches with 3 stall cycles: nothing lost or duplicated.
        lat = 1; n_br = 0; ack_limit = 10;
        do_reset();
        repeat (4) @(negedge clock);
        stall_from = cyc + 1; stall_to = cyc + 4;
        run(30, 1'b0);
        check32("s5_fetched", fidx, 32'd10);
        check32("s5_consumed", cidx, 32'd10);
`ifdef IF_FETCH_PERF_EN
        check32("s5_perf_fetch", perf_fetch, 32'd10);
        check32("s5_perf_stall", perf_stall, 32'd3);
`endif

        // Reset asserted mid-fetch with 3-cycle imem.
        lat = 3; ack_limit = 1000000;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (pc == 32'h8 && imem.req && !imem.ack) break;
        end
        check32("s6_mid_pc", pc, 32'h8);
        chk_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check32("s6_req", {31'd0, imem.req}, 32'd0);
        check32("s6_valid", {31'd0, d_valid}, 32'd0);
        check32("s6_pc", pc, T_RESET_PC);
        check32("s6_inst", d_inst, T_NOP);
        do_reset();
        run(30, 1'b1);
        check32("s6_recovered", {31'd0, fidx > 0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
